irq_prio_ctrl: RTL and testbench

Parametrised interrupt controller for the peripheral clock domain, generalising the 4-bit sticky status controller to NUM_IRQ channels. It detects events per channel (rising edge or level, selectable per channel at elaboration), latches them into a sticky pending register, and applies a per-channel enable mask. It arbitrates by fixed priority, where the lowest index wins, and presents a single interrupt with a channel ID through an assert/acknowledge handshake. It sits between peripheral IRQ sources and the CPU interrupt input.

---
 rtl/irq_prio_ctrl.sv | 107 ++++++++++
 tb/tb_irq_prio_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl: sticky-pending interrupt controller with per-channel edge/level
// detection, enable masking, fixed lowest-index-wins priority and an
// assert/acknowledge handshake towards the CPU.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no interrupt presented; picks the winner when a candidate exists
// ACTIVE | interrupt_o high, irq_id_o frozen until ack_i
// GAP    | one forced low cycle after an ack before re-arbitration
module irq_prio_ctrl #(
  parameter int                 NUM_IRQ   = 8,
  parameter int                 ID_W      = 3,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '1
) (
  input  logic               pclk_i,
  input  logic               rst_n_i,
  input  logic [NUM_IRQ-1:0] irq_request_i,
  input  logic [NUM_IRQ-1:0] irq_enable_i,
  input  logic               ack_i,
  output logic               interrupt_o,
  output logic [ID_W-1:0]    irq_id_o,
  output logic [NUM_IRQ-1:0] status_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] req_q;
  logic [NUM_IRQ-1:0] status;
  logic [NUM_IRQ-1:0] event_vec;
  logic [NUM_IRQ-1:0] candidates;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [NUM_IRQ-1:0] status_next;
  logic [ID_W-1:0]    winner;
  logic               any_cand;
  logic               ack_accept;
  logic               interrupt;
  logic [ID_W-1:0]    irq_id;

  // Edge channels fire on a 0->1 transition, level channels whenever high.
  assign event_vec  = irq_request_i & (~req_q | ~EDGE_MASK);
  assign candidates = status & irq_enable_i;
  assign any_cand   = |candidates;
  assign ack_accept = (state == ACTIVE) && ack_i;
  assign clr_vec    = ack_accept ? (NUM_IRQ'(1) << irq_id) : '0;
  // Set is OR-ed in after the clear so a same-cycle new event survives the ack.
  assign status_next = (status & ~clr_vec) | event_vec;

  // Fixed-priority pick: lowest set candidate index wins.
  always_comb begin
    logic found;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (candidates[i] && !found) begin
        winner = ID_W'(i);
        found  = 1'b1;
      end
    end
  end

  // Request history, pending register and handshake FSM with registered outputs.
  always_ff @(posedge pclk_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      req_q     <= '0;
      status    <= '0;
      interrupt <= 1'b0;
      irq_id    <= '0;
    end else begin
      req_q  <= irq_request_i;
      status <= status_next;
      case (state)
        IDLE: begin
          if (any_cand) begin
            irq_id    <= winner;
            interrupt <= 1'b1;
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (ack_i) begin
            interrupt <= 1'b0;
            state     <= GAP;
          end
        end
        GAP: begin
          interrupt <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          interrupt <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign interrupt_o = interrupt;
  assign irq_id_o    = irq_id;
  assign status_o    = status;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed bench for irq_prio_ctrl: channel 4 is level-sensitive, all others
// edge-sensitive. Expected interrupt IDs are queued as requests are driven and
// popped as each interrupt appears.
module tb_irq_prio_ctrl;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] en;
  logic       ack;
  logic       interrupt;
  logic [2:0] irq_id;
  logic [7:0] status;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  irq_prio_ctrl #(
    .NUM_IRQ  (8),
    .ID_W     (3),
    .EDGE_MASK(8'hEF)
  ) dut (
    .pclk_i       (pclk),
    .rst_n_i      (rst_n),
    .irq_request_i(req),
    .irq_enable_i (en),
    .ack_i        (ack),
    .interrupt_o  (interrupt),
    .irq_id_o     (irq_id),
    .status_o     (status)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] m);
    req = m;
    tick();
    req = '0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // exp_lat < 0 means only require the interrupt within two cycles.
  task automatic expect_irq(input string tag, input int exp_lat);
    int cnt;
    cnt = 0;
    while (interrupt !== 1'b1 && cnt < 10) begin
      tick();
      cnt++;
    end
    chk({tag, "_seen"}, {31'd0, interrupt}, 32'd1);
    if (exp_lat >= 0) chk({tag, "_lat"}, cnt, exp_lat);
    else chk({tag, "_lat_le2"}, {31'd0, cnt <= 2}, 32'd1);
    total++;
    if (exp_q.size() > 0) begin
      int e;
      e = exp_q.pop_front();
      assert (int'(irq_id) === e)
      else begin
        bad++;
        $error("FAIL %s_id observed=%0d expected=%0d", tag, irq_id, e);
      end
    end else begin
      bad++;
      $error("FAIL %s_id observed=%0d expected=none_queued", tag, irq_id);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    en    = 8'hFF;
    ack   = 1'b0;
    tick();
    tick();
    chk("rst_status", status, 0);
    chk("rst_int", interrupt, 0);
    chk("rst_id", irq_id, 0);
    rst_n = 1'b1;
    tick();

    // priority and handshake
    pulse(8'h05);
    chk("t1_status", status, 8'h05);
    chk("t1_int_low", interrupt, 0);
    exp_q.push_back(0);
    exp_q.push_back(2);
    expect_irq("t1_irq0", 1);
    do_ack();
    chk("t1_ack_status", status, 8'h04);
    chk("t1_ack_int", interrupt, 0);
    expect_irq("t1_irq2", 2);
    do_ack();
    chk("t1_ack2_status", status, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_stay_low", interrupt, 0);
    end

    // masking
    en = 8'hFE;
    pulse(8'h01);
    chk("t2_status", status, 8'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_masked_int", interrupt, 0);
      chk("t2_masked_status", status, 8'h01);
    end
    en = 8'hFF;
    exp_q.push_back(0);
    expect_irq("t2_unmask", -1);
    do_ack();
    chk("t2_ack_status", status, 8'h00);
    tick();

    // frozen ID
    pulse(8'h08);
    exp_q.push_back(3);
    expect_irq("t3_irq3", 1);
    pulse(8'h02);
    chk("t3_status", status, 8'h0A);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_frozen_id", irq_id, 3);
      chk("t3_frozen_int", interrupt, 1);
    end
    exp_q.push_back(1);
    do_ack();
    chk("t3_ack_status", status, 8'h02);
    expect_irq("t3_irq1", 2);
    do_ack();
    chk("t3_ack2_status", status, 8'h00);
    tick();

    // set wins over clear
    pulse(8'h04);
    exp_q.push_back(2);
    expect_irq("t4_irq2", 1);
    req = 8'h04;
    ack = 1'b1;
    tick();
    req = '0;
    ack = 1'b0;
    chk("t4_setwins_status", status, 8'h04);
    chk("t4_setwins_int", interrupt, 0);
    exp_q.push_back(2);
    expect_irq("t4_reirq2", 2);
    do_ack();
    chk("t4_ack_status", status, 8'h00);
    tick();

    // level channel 4 held high
    req = 8'h10;
    tick();
    chk("t5_lvl_status", status, 8'h10);
    for (int i = 0; i < 3; i++) exp_q.push_back(4);
    expect_irq("t5_lvl_1", 1);
    for (int i = 0; i < 2; i++) begin
      do_ack();
      chk("t5_lvl_repend", status, 8'h10);
      expect_irq("t5_lvl_n", 2);
    end
    req = '0;
    do_ack();
    chk("t5_lvl_done_status", status, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_lvl_done_int", interrupt, 0);
    end

    // edge channel 5 held high: exactly one interrupt
    req = 8'h20;
    tick();
    chk("t6_edge_status", status, 8'h20);
    exp_q.push_back(5);
    expect_irq("t6_edge", 1);
    do_ack();
    chk("t6_edge_clr", status, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_edge_once", interrupt, 0);
    end

    // reset mid-operation with requests held through it
    req = 8'h22;
    tick();
    chk("t7_status", status, 8'h02);
    exp_q.push_back(1);
    expect_irq("t7_irq1", 1);
    rst_n = 1'b0;
    tick();
    chk("t7_rst_int", interrupt, 0);
    chk("t7_rst_id", irq_id, 0);
    chk("t7_rst_status", status, 0);
    rst_n = 1'b1;
    tick();
    chk("t7_post_rst_status", status, 8'h22);
    exp_q.push_back(1);
    exp_q.push_back(5);
    expect_irq("t7_post_irq1", 1);
    do_ack();
    chk("t7_ack_status", status, 8'h20);
    expect_irq("t7_post_irq5", 2);
    do_ack();
    chk("t7_ack2_status", status, 8'h00);
    req = '0;

    // stray ack in IDLE
    ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t8_stray_int", interrupt, 0);
      chk("t8_stray_status", status, 0);
      chk("t8_stray_id", irq_id, 5);
    end
    ack = 1'b0;
    en  = 8'h00;
    pulse(8'h01);
    chk("t8_masked_status", status, 8'h01);
    ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t8_idle_ack_status", status, 8'h01);
      chk("t8_idle_ack_int", interrupt, 0);
    end
    ack = 1'b0;
    en  = 8'hFF;
    exp_q.push_back(0);
    expect_irq("t8_irq0", -1);
    do_ack();
    chk("t8_final_status", status, 8'h00);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
